// File: rtl/mem_read_arbiter_if.sv
// Bundle of the requester-side and memory-side read signals around the arbiter.
// No logic; the master modport is the arbiter's view, slave is the surroundings.
// Backpressure is carried by req_waitrequest / mem_waitrequest as plain wires.
interface mem_read_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    localparam int GW = $clog2(NUM_REQ);

    // requester side
    logic [NUM_REQ-1:0]            req_read;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
    logic [NUM_REQ-1:0]            req_waitrequest;
    logic [NUM_REQ-1:0]            req_readdatavalid;
    logic [DATA_WIDTH-1:0]         req_readdata;

    // memory side
    logic [ADDR_WIDTH-1:0]         mem_address;
    logic                          mem_read;
    logic [DATA_WIDTH-1:0]         mem_readdata;
    logic                          mem_readdatavalid;
    logic                          mem_waitrequest;

    // status
    logic [GW-1:0]                 grant_id;
    logic                          busy;
    logic                          protocol_err;

    // the arbiter itself
    modport master (
        input  req_read, req_address, mem_readdata, mem_readdatavalid, mem_waitrequest,
        output req_waitrequest, req_readdatavalid, req_readdata,
               mem_address, mem_read, grant_id, busy, protocol_err
    );

    // requesters plus memory, as seen from outside the arbiter
    modport slave (
        output req_read, req_address, mem_readdata, mem_readdatavalid, mem_waitrequest,
        input  req_waitrequest, req_readdatavalid, req_readdata,
               mem_address, mem_read, grant_id, busy, protocol_err
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Round-robin share of one memory read port among NUM_REQ masters, one read in flight.
// Latency: request->mem_read 1 cycle; accept and data return pass through combinationally.
// Backpressure: mem_waitrequest stalls ISSUE indefinitely; other masters wait in waitrequest.
module mem_read_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst,
    mem_read_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [15:0]   tmo_cnt;

    logic          pick_vld;
    logic [GW-1:0] pick_idx;
    logic          accept;
    logic          beat;

    // command handed to memory this cycle / data beat belonging to the granted read
    assign accept = (state == ISSUE) && !bus.mem_waitrequest;
    assign beat   = (state == WAIT_DATA) && bus.mem_readdatavalid;

    // Round-robin search starting just after the last accepted master. Walking the
    // offsets from farthest to nearest lets the nearest requester overwrite the others.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (bus.req_read[(int'(last_grant) + k) % NUM_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = GW'((int'(last_grant) + k) % NUM_REQ);
            end
        end
    end

    // Per-master handshake strobes: only the granted master ever sees an accept or a beat.
    always_comb begin
        bus.req_waitrequest   = '1;
        bus.req_readdatavalid = '0;
        if (!rst && accept) begin
            bus.req_waitrequest[bus.grant_id] = 1'b0;
        end
        if (!rst && beat) begin
            bus.req_readdatavalid[bus.grant_id] = 1'b1;
        end
    end

    // Return data is a straight wire; the strobe above says whose it is.
    assign bus.req_readdata = bus.mem_readdata;

    // Arbitration FSM with all memory-side and status outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            last_grant       <= GW'(NUM_REQ - 1);
            tmo_cnt          <= '0;
            bus.mem_read     <= 1'b0;
            bus.mem_address  <= '0;
            bus.grant_id     <= '0;
            bus.busy         <= 1'b0;
            bus.protocol_err <= 1'b0;
        end else begin
            // A beat with no read waiting for it belongs to nobody (e.g. issued before a reset).
            if (bus.mem_readdatavalid && (state != WAIT_DATA)) begin
                bus.protocol_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        bus.grant_id    <= pick_idx;
                        bus.mem_address <= bus.req_address[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        bus.mem_read    <= 1'b1;
                        bus.busy        <= 1'b1;
                        state           <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Priority only rotates once the command is actually taken.
                    if (!bus.mem_waitrequest) begin
                        bus.mem_read <= 1'b0;
                        last_grant   <= bus.grant_id;
                        tmo_cnt      <= '0;
                        state        <= WAIT_DATA;
                    end
                end

                WAIT_DATA: begin
                    // A beat on the final timeout cycle still wins over the timeout.
                    if (bus.mem_readdatavalid) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (tmo_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        bus.protocol_err <= 1'b1;
                        bus.busy         <= 1'b0;
                        state            <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                default: begin
                    bus.mem_read <= 1'b0;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule
